// File: rtl/point_pkg.sv
// point_pkg: shared types and helpers for the point-population path.
//   DEFAULT_MAX_DIM / DEFAULT_COORD_W : default point dimension and coordinate width
//   coord_t  : one signed coordinate at the default width
//   state_t  : serializer FSM state (IDLE, SEND)
//   dim_ok() : 1 when 1 <= dim <= max_dim
package point_pkg;

    localparam int DEFAULT_MAX_DIM = 3;
    localparam int DEFAULT_COORD_W = 32;

    typedef logic signed [DEFAULT_COORD_W-1:0] coord_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic dim_ok(input int dim, input int max_dim);
        return (dim >= 1) && (dim <= max_dim);
    endfunction

endpackage

// File: rtl/point_serializer.sv
// point_serializer: accepts one N-dimensional point per input handshake and
// streams its coordinates out one per beat, with index and last flag.
// Points with an out-of-range dimension are consumed and flagged on err_dim.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input point handshake
//   in_dim              coordinate count of the offered point
//   in_coords           packed coordinates, coord k at [k*COORD_W +: COORD_W]
//   out_valid/out_ready output beat handshake
//   out_coord           signed coordinate value of the current beat
//   out_idx             coordinate index of the current beat
//   out_last            current beat is the final coordinate of its point
//   err_dim             one-cycle pulse after a point with a bad dim is consumed
//   pt_count            points fully emitted since reset (wraps)
module point_serializer
    import point_pkg::*;
#(
    parameter int MAX_DIM = DEFAULT_MAX_DIM,
    parameter int COORD_W = DEFAULT_COORD_W,
    parameter int CNT_W   = 16,
    localparam int DIM_W  = $clog2(MAX_DIM + 1),
    localparam int IDX_W  = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DIM_W-1:0]            in_dim,
    input  logic [MAX_DIM*COORD_W-1:0]  in_coords,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [COORD_W-1:0]   out_coord,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        out_last,
    output logic                        err_dim,
    output logic [CNT_W-1:0]            pt_count
);

    state_t                             state_q;
    logic [DIM_W-1:0]                   dim_q;
    logic [IDX_W-1:0]                   idx_q;
    logic [MAX_DIM-1:0][COORD_W-1:0]    coord_q;
    logic                               err_q;
    logic [CNT_W-1:0]                   cnt_q;

    logic in_send;
    logic is_last;
    logic accept;
    logic good_dim;
    logic load;
    logic beat;

    assign in_send  = (state_q == SEND);
    assign is_last  = in_send && ((32'(idx_q) + 32'd1) == 32'(dim_q));

    // Ready in IDLE, or on the last beat of a point so the next point can
    // follow without a bubble.
    assign in_ready = !in_send || (out_ready && is_last);
    assign accept   = in_valid && in_ready;
    assign good_dim = dim_ok(int'(32'(in_dim)), MAX_DIM);
    assign load     = accept && good_dim;
    assign beat     = in_send && out_ready;

    assign out_valid = in_send;
    assign out_idx   = in_send ? idx_q : '0;
    assign out_last  = is_last;
    assign err_dim   = err_q;
    assign pt_count  = cnt_q;

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        out_coord = '0;
        for (int k = 0; k < MAX_DIM; k++) begin
            if (in_send && (idx_q == IDX_W'(k))) begin
                out_coord = coord_q[k];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dim_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= accept && !good_dim;

            if (beat && is_last) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= SEND;
                        dim_q   <= in_dim;
                        idx_q   <= '0;
                    end
                end
                SEND: begin
                    if (beat) begin
                        if (!is_last) begin
                            idx_q <= idx_q + IDX_W'(1);
                        end else if (load) begin
                            dim_q <= in_dim;
                            idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the coordinate buffer has no reset; its contents are only
    // visible while in SEND, which is entered only after a fresh load.
    always_ff @(posedge clk) begin
        if (load) begin
            coord_q <= in_coords;
        end
    end

endmodule

// File: tb/tb_point_serializer.sv
// Directed self-checking bench for point_serializer.
// Main DUT: MAX_DIM=3, COORD_W=32, CNT_W=2 (small counter so wrap is reachable).
// Second DUT: MAX_DIM=2, so an in_dim above MAX_DIM is representable.
module tb_point_serializer;
    import point_pkg::*;

    localparam int MAX_DIM = 3;
    localparam int COORD_W = 32;
    localparam int CNT_W   = 2;
    localparam int DIM_W   = 2;
    localparam int IDX_W   = 2;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic [DIM_W-1:0]           in_dim = '0;
    logic [MAX_DIM*COORD_W-1:0] in_coords = '0;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic signed [COORD_W-1:0]  out_coord;
    logic [IDX_W-1:0]           out_idx;
    logic                       out_last;
    logic                       err_dim;
    logic [CNT_W-1:0]           pt_count;

    logic                       b_in_valid = 1'b0;
    logic                       b_in_ready;
    logic [1:0]                 b_in_dim = '0;
    logic [2*COORD_W-1:0]       b_in_coords = '0;
    logic                       b_out_valid;
    logic signed [COORD_W-1:0]  b_out_coord;
    logic [0:0]                 b_out_idx;
    logic                       b_out_last;
    logic                       b_err_dim;
    logic [CNT_W-1:0]           b_pt_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    point_serializer #(.MAX_DIM(MAX_DIM), .COORD_W(COORD_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_dim(in_dim), .in_coords(in_coords),
        .out_valid(out_valid), .out_ready(out_ready), .out_coord(out_coord),
        .out_idx(out_idx), .out_last(out_last), .err_dim(err_dim), .pt_count(pt_count)
    );

    point_serializer #(.MAX_DIM(2), .COORD_W(COORD_W), .CNT_W(CNT_W)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_dim(b_in_dim), .in_coords(b_in_coords),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_coord(b_out_coord),
        .out_idx(b_out_idx), .out_last(b_out_last), .err_dim(b_err_dim), .pt_count(b_pt_count)
    );

    function automatic logic [MAX_DIM*COORD_W-1:0] pack3(input coord_t c0, input coord_t c1, input coord_t c2);
        return {c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        in_dim     = '0;
        in_coords  = '0;
        out_ready  = 1'b0;
        b_in_valid = 1'b0;
        rst_n      = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total_cnt += 5;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else pass_cnt++;
        if (err_dim !== 1'b0) $display("FAIL reset_err_dim got=%0b exp=0", err_dim); else pass_cnt++;
        if (pt_count !== 2'd0) $display("FAIL reset_pt_count got=%0d exp=0", pt_count); else pass_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready); else pass_cnt++;
        if (out_coord !== 32'sd0 || out_idx !== 2'd0 || out_last !== 1'b0)
            $display("FAIL reset_out_fields got=%0d/%0d/%0b exp=0/0/0", out_coord, out_idx, out_last);
        else pass_cnt++;

        // one dim=1 point with a negative coordinate, then reset mid dim=3 point
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_dim    = 2'd1;
        in_coords = pack3(-9, 0, 0);
        tick();
        in_dim    = 2'd3;
        in_coords = pack3(10, -20, 30);
        @(negedge clk);
        total_cnt++;
        if (out_coord !== -32'sd9 || out_last !== 1'b1)
            $display("FAIL reset_neg_coord got=%0d last=%0b exp=-9 last=1", out_coord, out_last);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (pt_count !== 2'd1 || out_coord !== 32'sd10)
            $display("FAIL reset_pre_state got=%0d/%0d exp=1/10", pt_count, out_coord);
        else pass_cnt++;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || pt_count !== 2'd0 || err_dim !== 1'b0 ||
            out_idx !== 2'd0 || out_last !== 1'b0 || out_coord !== 32'sd0)
            $display("FAIL reset_async got=v%0b r%0b c%0d e%0b i%0d l%0b d%0d exp=v0 r1 c0 e0 i0 l0 d0",
                     out_valid, in_ready, pt_count, err_dim, out_idx, out_last, out_coord);
        else pass_cnt++;
        tick();
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_dim    = 2'd1;
        in_coords = pack3(42, 0, 0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_coord !== 32'sd42 || out_last !== 1'b1)
            $display("FAIL reset_after_release got=v%0b %0d l%0b exp=v1 42 l1", out_valid, out_coord, out_last);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (pt_count !== 2'd1 || out_valid !== 1'b0)
            $display("FAIL reset_after_count got=%0d v%0b exp=1 v0", pt_count, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_single_3d();
        coord_t exp_c[3] = '{32'sd3, 32'sd4, 32'sd5};
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_dim    = 2'd3;
        in_coords = pack3(3, 4, 5);
        tick();
        in_valid  = 1'b0;
        in_coords = pack3(99, 99, 99);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || out_coord !== exp_c[b] || out_idx !== IDX_W'(b) ||
                out_last !== (b == 2) || in_ready !== (b == 2))
                $display("FAIL single_beat%0d got=v%0b %0d i%0d l%0b r%0b exp=v1 %0d i%0d l%0b r%0b",
                         b, out_valid, out_coord, out_idx, out_last, in_ready,
                         exp_c[b], b, (b == 2), (b == 2));
            else pass_cnt++;
            tick();
        end
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || pt_count !== 2'd1)
            $display("FAIL single_done got=v%0b c%0d exp=v0 c1", out_valid, pt_count);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_dim    = 2'd2;
        in_coords = pack3(6, 7, 0);
        tick();
        in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || out_coord !== 32'sd6 || out_idx !== 2'd0 ||
                out_last !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d got=v%0b %0d i%0d l%0b r%0b exp=v1 6 i0 l0 r0",
                         s, out_valid, out_coord, out_idx, out_last, in_ready);
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_coord !== 32'sd6 || out_idx !== 2'd0 || in_ready !== 1'b0)
            $display("FAIL bp_beat0 got=%0d i%0d r%0b exp=6 i0 r0", out_coord, out_idx, in_ready);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (out_coord !== 32'sd7 || out_idx !== 2'd1 || out_last !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL bp_beat1 got=%0d i%0d l%0b r%0b exp=7 i1 l1 r1", out_coord, out_idx, out_last, in_ready);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || pt_count !== 2'd1)
            $display("FAIL bp_done got=v%0b c%0d exp=v0 c1", out_valid, pt_count);
        else pass_cnt++;
    endtask

    task automatic test_bad_dims();
        do_reset();
        out_ready = 1'b1;
        // dim=0 on the main DUT, dim=3 on the MAX_DIM=2 DUT
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                in_valid = 1'b1;
                in_dim   = 2'd0;
            end else begin
                b_in_valid = 1'b1;
                b_in_dim   = 2'd3;
            end
            tick();
            in_valid   = 1'b0;
            b_in_valid = 1'b0;
            @(negedge clk);
            total_cnt++;
            if (t == 0 ? (err_dim !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1)
                       : (b_err_dim !== 1'b1 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1))
                $display("FAIL bad_dim%0d_pulse got=e%0b v%0b r%0b exp=e1 v0 r1", t,
                         t == 0 ? err_dim : b_err_dim, t == 0 ? out_valid : b_out_valid,
                         t == 0 ? in_ready : b_in_ready);
            else pass_cnt++;
            tick();
            @(negedge clk);
            total_cnt++;
            if (t == 0 ? (err_dim !== 1'b0 || out_valid !== 1'b0 || pt_count !== 2'd0)
                       : (b_err_dim !== 1'b0 || b_out_valid !== 1'b0 || b_pt_count !== 2'd0))
                $display("FAIL bad_dim%0d_after got=e%0b v%0b c%0d exp=e0 v0 c0", t,
                         t == 0 ? err_dim : b_err_dim, t == 0 ? out_valid : b_out_valid,
                         t == 0 ? pt_count : b_pt_count);
            else pass_cnt++;
        end
        // MAX_DIM itself is a valid dim on the second DUT
        b_in_valid  = 1'b1;
        b_in_dim    = 2'd2;
        b_in_coords = {32'sd8, -32'sd1};
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (b_err_dim !== 1'b0 || b_out_valid !== 1'b1 || b_out_coord !== -32'sd1)
            $display("FAIL max_dim_ok got=e%0b v%0b %0d exp=e0 v1 -1", b_err_dim, b_out_valid, b_out_coord);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (b_out_coord !== 32'sd8 || b_out_idx !== 1'b1 || b_out_last !== 1'b1)
            $display("FAIL max_dim_last got=%0d i%0d l%0b exp=8 i1 l1", b_out_coord, b_out_idx, b_out_last);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_dim    = 2'd1;
        in_coords = pack3(3, 0, 0);
        tick();
        in_dim    = 2'd2;
        in_coords = pack3(4, 5, 0);
        @(negedge clk);
        total_cnt++;
        if (out_coord !== 32'sd3 || out_idx !== 2'd0 || out_last !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL b2b_beat0 got=%0d i%0d l%0b r%0b exp=3 i0 l1 r1", out_coord, out_idx, out_last, in_ready);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_coord !== 32'sd4 || out_idx !== 2'd0 || out_last !== 1'b0 || pt_count !== 2'd1)
            $display("FAIL b2b_beat1 got=v%0b %0d i%0d l%0b c%0d exp=v1 4 i0 l0 c1",
                     out_valid, out_coord, out_idx, out_last, pt_count);
        else pass_cnt++;
        tick();
        // bad dim offered alongside the last beat: consumed, flagged, back to IDLE
        in_valid = 1'b1;
        in_dim   = 2'd0;
        @(negedge clk);
        total_cnt++;
        if (out_coord !== 32'sd5 || out_idx !== 2'd1 || out_last !== 1'b1)
            $display("FAIL b2b_beat2 got=%0d i%0d l%0b exp=5 i1 l1", out_coord, out_idx, out_last);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || err_dim !== 1'b1 || pt_count !== 2'd2)
            $display("FAIL b2b_end got=v%0b e%0b c%0d exp=v0 e1 c2", out_valid, err_dim, pt_count);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_counter_wrap();
        logic [CNT_W-1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_dim    = 2'd1;
        in_coords = pack3(11, 0, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 3) in_valid = 1'b0;
            @(negedge clk);
            total_cnt++;
            if (pt_count !== exp_cnt[k])
                $display("FAIL wrap_count%0d got=%0d exp=%0d", k, pt_count, exp_cnt[k]);
            else pass_cnt++;
        end
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL wrap_idle got=v%0b exp=v0", out_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_3d();
        test_backpressure();
        test_bad_dims();
        test_back_to_back();
        test_counter_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
